// File: rtl/toy_wb_arbiter.sv
// Writeback-port arbiter: grants up to WB_PORT_NUM execution-unit results per
// cycle in round-robin order and registers the winners onto the register-file
// write ports with one cycle of latency.
module toy_wb_arbiter #(
  parameter int EU_NUM         = 4,
  parameter int WB_PORT_NUM    = 2,
  parameter int REG_WIDTH      = 64,
  parameter int PREG_IDX_WIDTH = 7,
  parameter int EU_ID_WIDTH    = $clog2(EU_NUM)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [EU_NUM-1:0]                          v_eu_wb_vld,
  input  logic [EU_NUM-1:0][REG_WIDTH-1:0]           v_eu_wb_data,
  input  logic [EU_NUM-1:0][PREG_IDX_WIDTH-1:0]      v_eu_wb_prd,
  output logic [EU_NUM-1:0]                          v_eu_wb_rdy,
  input  logic                                       wb_en,
  output logic [WB_PORT_NUM-1:0]                     v_wr_reg_en,
  output logic [WB_PORT_NUM-1:0][REG_WIDTH-1:0]      v_wr_reg_data,
  output logic [WB_PORT_NUM-1:0][PREG_IDX_WIDTH-1:0] v_wr_reg_prd,
  output logic [WB_PORT_NUM-1:0][EU_ID_WIDTH-1:0]    v_wr_reg_eu_id,
  output logic [EU_ID_WIDTH-1:0]                     rr_ptr
);

  // Port-slot counter width; one extra bit so it can reach WB_PORT_NUM.
  localparam int PSEL_W = (WB_PORT_NUM > 1) ? $clog2(WB_PORT_NUM) : 1;
  localparam logic [PSEL_W:0] PORT_LIMIT = (PSEL_W + 1)'(WB_PORT_NUM);

  // (base + off) mod EU_NUM; works for EU_NUM that is not a power of two.
  function automatic logic [EU_ID_WIDTH-1:0] wrap_add(
    input logic [EU_ID_WIDTH-1:0] base,
    input int unsigned            off
  );
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(EU_NUM)) s = s - 32'(EU_NUM);
    return s[EU_ID_WIDTH-1:0];
  endfunction

  logic [EU_ID_WIDTH-1:0]                  rr_ptr_reg;
  logic [EU_ID_WIDTH-1:0]                  rr_ptr_next;
  logic [EU_NUM-1:0]                       grant;
  logic [WB_PORT_NUM-1:0]                  port_vld;
  logic [WB_PORT_NUM-1:0][EU_ID_WIDTH-1:0] port_sel;
  logic [EU_ID_WIDTH-1:0]                  last_idx;
  logic [EU_ID_WIDTH-1:0]                  scan_idx;
  logic [PSEL_W:0]                         slot;

  // Rotating-priority scan: the k-th valid EU found from rr_ptr takes port k.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_sel = '0;
    last_idx = rr_ptr_reg;
    scan_idx = '0;
    slot     = '0;
    for (int unsigned off = 0; off < 32'(EU_NUM); off++) begin
      scan_idx = wrap_add(rr_ptr_reg, off);
      if (!rst && wb_en && v_eu_wb_vld[scan_idx] && (slot < PORT_LIMIT)) begin
        grant[scan_idx]              = 1'b1;
        port_vld[slot[PSEL_W-1:0]]   = 1'b1;
        port_sel[slot[PSEL_W-1:0]]   = scan_idx;
        last_idx                     = scan_idx;
        slot                         = slot + 1'b1;
      end
    end
    // Priority moves just past the last winner so skipped EUs lead next time.
    rr_ptr_next = (|grant) ? wrap_add(last_idx, 1) : rr_ptr_reg;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_reg <= '0;
    else     rr_ptr_reg <= rr_ptr_next;
  end

  assign v_eu_wb_rdy = grant;
  assign rr_ptr      = rr_ptr_reg;

  logic                      en_reg    [WB_PORT_NUM];
  logic [REG_WIDTH-1:0]      data_reg  [WB_PORT_NUM];
  logic [PREG_IDX_WIDTH-1:0] prd_reg   [WB_PORT_NUM];
  logic [EU_ID_WIDTH-1:0]    eu_id_reg [WB_PORT_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < WB_PORT_NUM; gi++) begin : g_port
      // Capture the granted EU for this port; idle ports keep their payload.
      always_ff @(posedge clk) begin
        if (rst) begin
          en_reg[gi]    <= 1'b0;
          data_reg[gi]  <= '0;
          prd_reg[gi]   <= '0;
          eu_id_reg[gi] <= '0;
        end else begin
          en_reg[gi] <= port_vld[gi];
          if (port_vld[gi]) begin
            data_reg[gi]  <= v_eu_wb_data[port_sel[gi]];
            prd_reg[gi]   <= v_eu_wb_prd[port_sel[gi]];
            eu_id_reg[gi] <= port_sel[gi];
          end
        end
      end

      assign v_wr_reg_en[gi]    = en_reg[gi];
      assign v_wr_reg_data[gi]  = data_reg[gi];
      assign v_wr_reg_prd[gi]   = prd_reg[gi];
      assign v_wr_reg_eu_id[gi] = eu_id_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_toy_wb_arbiter.sv
// Scoreboard bench for toy_wb_arbiter: directed scenarios followed by random
// traffic, checked against a rotated-priority reference model.
module tb_toy_wb_arbiter;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int RW = 64;
  localparam int PW = 7;
  localparam int IW = 2;

  logic                     clk;
  logic                     rst;
  logic [N-1:0]             v_eu_wb_vld;
  logic [N-1:0][RW-1:0]     v_eu_wb_data;
  logic [N-1:0][PW-1:0]     v_eu_wb_prd;
  logic [N-1:0]             v_eu_wb_rdy;
  logic                     wb_en;
  logic [P-1:0]             v_wr_reg_en;
  logic [P-1:0][RW-1:0]     v_wr_reg_data;
  logic [P-1:0][PW-1:0]     v_wr_reg_prd;
  logic [P-1:0][IW-1:0]     v_wr_reg_eu_id;
  logic [IW-1:0]            rr_ptr;

  toy_wb_arbiter #(
    .EU_NUM(N), .WB_PORT_NUM(P), .REG_WIDTH(RW), .PREG_IDX_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .v_eu_wb_vld(v_eu_wb_vld), .v_eu_wb_data(v_eu_wb_data),
    .v_eu_wb_prd(v_eu_wb_prd), .v_eu_wb_rdy(v_eu_wb_rdy),
    .wb_en(wb_en),
    .v_wr_reg_en(v_wr_reg_en), .v_wr_reg_data(v_wr_reg_data),
    .v_wr_reg_prd(v_wr_reg_prd), .v_wr_reg_eu_id(v_wr_reg_eu_id),
    .rr_ptr(rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    int          eu;
    logic [6:0]  prd;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_ptr    = 0;
  int          waited[N];
  logic [63:0] eu_data[N];
  logic [6:0]  eu_prd[N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check rdy/rr_ptr, push expected writes.
  task automatic drive_cycle(input logic [N-1:0] vld, input logic en, input logic r,
                             output logic [N-1:0] rdy_o);
    int          keys[$];
    int          idx;
    int          nptr;
    logic [N-1:0] g;
    @(negedge clk);
    rst         = r;
    wb_en       = en;
    v_eu_wb_vld = vld;
    for (int i = 0; i < N; i++) begin
      v_eu_wb_data[i] = eu_data[i];
      v_eu_wb_prd[i]  = eu_prd[i];
    end
    #1;
    rdy_o = v_eu_wb_rdy;
    g     = '0;
    nptr  = m_ptr;
    if (!r && en) begin
      // Distance from the priority pointer decides order; lowest P win.
      for (int i = 0; i < N; i++)
        if (vld[i]) keys.push_back((i - m_ptr + N) % N);
      keys.sort();
      for (int k = 0; k < keys.size() && k < P; k++) begin
        idx    = (keys[k] + m_ptr) % N;
        g[idx] = 1'b1;
        exp_q.push_back('{k, idx, eu_prd[idx], eu_data[idx]});
        nptr   = (idx + 1) % N;
      end
    end
    chk("rdy", 128'(rdy_o), 128'(g));
    chk("rr_ptr", 128'(rr_ptr), 128'(m_ptr));
    $display("cycle rst=%0b wb_en=%0b vld=%b rdy=%b ptr=%0d", r, en, vld, rdy_o, rr_ptr);
    // Fairness: a held request waits at most ceil(N/P)-1 enabled cycles.
    for (int i = 0; i < N; i++) begin
      if (r || !vld[i]) waited[i] = 0;
      else if (en) begin
        if (g[i]) begin
          chk("fairness", 128'(waited[i] <= 1), 128'(1));
          waited[i] = 0;
        end else waited[i]++;
      end
    end
    m_ptr = r ? 0 : nptr;
  endtask

  // Monitor: every enabled write port must match the next expected write.
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int k = 0; k < P; k++) begin
      if (v_wr_reg_en[k]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: port %0d eu %0d with no expected write", k, v_wr_reg_eu_id[k]);
        end else begin
          e = exp_q.pop_front();
          chk("wr_port", 128'(k), 128'(e.port));
          chk("wr_eu_id", 128'(v_wr_reg_eu_id[k]), 128'(e.eu));
          chk("wr_prd", 128'(v_wr_reg_prd[k]), 128'(e.prd));
          chk("wr_data", 128'(v_wr_reg_data[k]), 128'(e.data));
          $display("write port=%0d eu=%0d prd=%0d data=%0h", k, v_wr_reg_eu_id[k], v_wr_reg_prd[k], v_wr_reg_data[k]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rdy;
    logic [N-1:0] req;
    logic         r_en;
    logic         r_rst;
    rst = 1'b1; wb_en = 1'b0; v_eu_wb_vld = '0; v_eu_wb_data = '0; v_eu_wb_prd = '0;
    for (int i = 0; i < N; i++) begin
      waited[i]  = 0;
      eu_data[i] = 64'h1000 + 64'(i);
      eu_prd[i]  = 7'(10 + i);
    end

    // Reset with every EU requesting.
    drive_cycle(4'b1111, 1'b1, 1'b1, rdy);
    drive_cycle(4'b1111, 1'b1, 1'b1, rdy);
    chk("reset_rdy", 128'(rdy), 128'(0));
    @(posedge clk); #1;
    chk("reset_en", 128'(v_wr_reg_en), 128'(0));
    chk("reset_data", 128'(v_wr_reg_data), 128'(0));
    chk("reset_prd", 128'(v_wr_reg_prd), 128'(0));
    chk("reset_eu_id", 128'(v_wr_reg_eu_id), 128'(0));
    chk("reset_ptr", 128'(rr_ptr), 128'(0));
    drive_cycle(4'b1111, 1'b1, 1'b0, rdy);
    chk("first_rdy", 128'(rdy), 128'(4'b0011));

    // Single request from EU2.
    eu_prd[2] = 7'd5; eu_data[2] = 64'hDEAD;
    drive_cycle(4'b0100, 1'b1, 1'b0, rdy);
    chk("single_ptr_before", 128'(rr_ptr), 128'(2));
    chk("single_rdy", 128'(rdy), 128'(4'b0100));

    // Wrap-around from pointer 3.
    drive_cycle(4'b1011, 1'b1, 1'b0, rdy);
    chk("wrap_ptr_before", 128'(rr_ptr), 128'(3));
    chk("wrap_rdy", 128'(rdy), 128'(4'b1001));

    // Bring pointer back to 0 via a lone EU3 grant.
    drive_cycle(4'b1000, 1'b1, 1'b0, rdy);
    chk("wrap_ptr_after", 128'(rr_ptr), 128'(1));

    // Sustained full load.
    for (int c = 0; c < 4; c++) begin
      drive_cycle(4'b1111, 1'b1, 1'b0, rdy);
      chk("full_rdy", 128'(rdy), 128'((c % 2 == 0) ? 4'b0011 : 4'b1100));
    end

    // Backpressure holds the pointer.
    for (int c = 0; c < 3; c++) begin
      drive_cycle(4'b1111, 1'b0, 1'b0, rdy);
      chk("bp_rdy", 128'(rdy), 128'(0));
    end
    drive_cycle(4'b1111, 1'b1, 1'b0, rdy);
    chk("bp_resume_rdy", 128'(rdy), 128'(4'b0011));

    // Reset right after a {2,3} grant.
    drive_cycle(4'b1111, 1'b1, 1'b0, rdy);
    chk("mid_rdy", 128'(rdy), 128'(4'b1100));
    drive_cycle(4'b1111, 1'b1, 1'b1, rdy);
    @(posedge clk); #1;
    chk("mid_reset_en", 128'(v_wr_reg_en), 128'(0));
    chk("mid_reset_ptr", 128'(rr_ptr), 128'(0));
    drive_cycle(4'b1100, 1'b1, 1'b0, rdy);
    chk("post_reset_rdy", 128'(rdy), 128'(4'b1100));

    // Random traffic: EUs hold requests until accepted.
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]     = 1'b1;
          eu_data[i] = {$urandom, $urandom};
          eu_prd[i]  = 7'($urandom_range(0, 127));
        end
      end
      r_en  = ($urandom_range(0, 3) != 0);
      r_rst = ($urandom_range(0, 63) == 0);
      drive_cycle(req, r_en, r_rst, rdy);
      req = req & ~rdy;
    end

    drive_cycle('0, 1'b1, 1'b0, rdy);
    drive_cycle('0, 1'b1, 1'b0, rdy);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
